banked_regfile_stack: RTL and testbench

Stacked register file that responds to the command/read/write port set driven by the regfile stimulus and core front-ends. It holds DEPTH frames of 32 x WIDTH registers, one frame active at a time. A 2-bit command pushes, pops or flushes frames for interrupt context switching. It sits between the decode stage, which drives two read ports and one write port, and the interrupt controller, which drives the command.

---
 rtl/banked_regfile_stack_pkg.sv | 17 +
 rtl/banked_regfile_stack_regfile_bank.sv | 43 ++++
 rtl/banked_regfile_stack.sv | 119 +++++++++++
 tb/tb_banked_regfile_stack.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/banked_regfile_stack_pkg.sv
// rtl/banked_regfile_stack_pkg.sv - shared types and defaults for the banked register file stack
// Contents: frame command encoding, default DEPTH/WIDTH/ADDR_W, frame index width.
package banked_regfile_stack_pkg;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_PUSH  = 2'd1,
    CMD_POP   = 2'd2,
    CMD_FLUSH = 2'd3
  } cmd_t;

  localparam int DEPTH_DEF   = 4;
  localparam int WIDTH_DEF   = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int DEPTH_W_DEF = $clog2(DEPTH_DEF);

endpackage

// File: rtl/banked_regfile_stack_regfile_bank.sv
// rtl/banked_regfile_stack_regfile_bank.sv - one register frame with valid mask and two read ports
// Ports: i_clk, i_reset (sync, active-high), i_clear (clears valid mask),
//   i_w_ena/i_w_addr/i_w_data write port, i_a_addr/i_b_addr -> o_a_data/o_b_data.
// Unwritten registers and register 0 read as zero via the valid mask.
module regfile_bank #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_clear,
  input  logic              i_w_ena,
  input  logic [ADDR_W-1:0] i_w_addr,
  input  logic [WIDTH-1:0]  i_w_data,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [ADDR_W-1:0] i_b_addr,
  output logic [WIDTH-1:0]  o_a_data,
  output logic [WIDTH-1:0]  o_b_data
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [NREGS];
  logic [NREGS-1:0] valid;
  logic             wr_hit;

  assign wr_hit = i_w_ena && (i_w_addr != '0);

  // Storage itself is never reset; the valid mask alone decides visibility.
  always_ff @(posedge i_clk) begin
    if (wr_hit) mem[i_w_addr] <= i_w_data;
  end

  // Clear beats a same-cycle write so a flushed frame reads all-zero.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) valid <= '0;
    else if (wr_hit)        valid[i_w_addr] <= 1'b1;
  end

  assign o_a_data = valid[i_a_addr] ? mem[i_a_addr] : '0;
  assign o_b_data = valid[i_b_addr] ? mem[i_b_addr] : '0;

endmodule

// File: rtl/banked_regfile_stack.sv
// rtl/banked_regfile_stack.sv - stack of register frames switched by push/pop/flush commands
// Ports: i_clk, i_reset (sync, active-high), i_command (NONE/PUSH/POP/FLUSH),
//   i_a_addr/i_b_addr -> o_a_data/o_b_data (active frame, combinational),
//   i_w_ena/i_w_addr/i_w_data write into active frame, o_depth active frame index,
//   o_full/o_empty, sticky o_overflow/o_underflow.
// Option: BANKED_REGFILE_STACK_BYPASS_EN forwards same-cycle write data to matching read ports.
module banked_regfile_stack
  import banked_regfile_stack_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [1:0]               i_command,
  input  logic [ADDR_W-1:0]        i_a_addr,
  input  logic [ADDR_W-1:0]        i_b_addr,
  input  logic                     i_w_ena,
  input  logic [ADDR_W-1:0]        i_w_addr,
  input  logic [WIDTH-1:0]         i_w_data,
  output logic [WIDTH-1:0]         o_a_data,
  output logic [WIDTH-1:0]         o_b_data,
  output logic [$clog2(DEPTH)-1:0] o_depth,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow,
  output logic                     o_underflow
);

  localparam int DEPTH_W = $clog2(DEPTH);

  cmd_t               cmd;
  logic [DEPTH_W-1:0] depth;
  logic [DEPTH_W-1:0] depth_up;
  logic               full;
  logic               empty;
  logic [DEPTH-1:0]   bank_clear;
  logic [DEPTH-1:0]   bank_w_ena;
  logic [WIDTH-1:0]   bank_a [DEPTH];
  logic [WIDTH-1:0]   bank_b [DEPTH];
  logic [WIDTH-1:0]   sel_a;
  logic [WIDTH-1:0]   sel_b;

  assign cmd      = cmd_t'(i_command);
  assign depth_up = depth + 1'b1;
  assign full     = (depth == DEPTH_W'(DEPTH - 1));
  assign empty    = (depth == '0);

  // A successful push wipes the frame being entered; flush wipes every frame.
  always_comb begin
    bank_clear = '0;
    if (cmd == CMD_FLUSH)                bank_clear = '1;
    else if ((cmd == CMD_PUSH) && !full) bank_clear[depth_up] = 1'b1;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_bank
    assign bank_w_ena[g] = i_w_ena && (depth == DEPTH_W'(g));

    regfile_bank #(
      .WIDTH  (WIDTH),
      .ADDR_W (ADDR_W)
    ) u_bank (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_clear  (bank_clear[g]),
      .i_w_ena  (bank_w_ena[g]),
      .i_w_addr (i_w_addr),
      .i_w_data (i_w_data),
      .i_a_addr (i_a_addr),
      .i_b_addr (i_b_addr),
      .o_a_data (bank_a[g]),
      .o_b_data (bank_b[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      depth       <= '0;
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      case (cmd)
        CMD_PUSH: begin
          if (full) o_overflow <= 1'b1;
          else      depth      <= depth_up;
        end
        CMD_POP: begin
          if (empty) o_underflow <= 1'b1;
          else       depth       <= depth - 1'b1;
        end
        CMD_FLUSH: begin
          depth       <= '0;
          o_overflow  <= 1'b0;
          o_underflow <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign sel_a = bank_a[depth];
  assign sel_b = bank_b[depth];

`ifdef BANKED_REGFILE_STACK_BYPASS_EN
  logic fwd_ok;
  assign fwd_ok   = i_w_ena && (i_w_addr != '0);
  assign o_a_data = (fwd_ok && (i_w_addr == i_a_addr)) ? i_w_data : sel_a;
  assign o_b_data = (fwd_ok && (i_w_addr == i_b_addr)) ? i_w_data : sel_b;
`else
  assign o_a_data = sel_a;
  assign o_b_data = sel_b;
`endif

  assign o_depth = depth;
  assign o_full  = full;
  assign o_empty = empty;

endmodule

// File: tb/tb_banked_regfile_stack.sv
// tb/tb_banked_regfile_stack.sv - directed self-checking bench for banked_regfile_stack
module tb_banked_regfile_stack;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cmd;
  logic [4:0]  a_addr, b_addr, w_addr;
  logic        w_ena;
  logic [31:0] w_data;
  logic [31:0] a_data, b_data;
  logic [1:0]  depth;
  logic        full, empty, ovf, unf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  banked_regfile_stack dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_command   (cmd),
    .i_a_addr    (a_addr),
    .i_b_addr    (b_addr),
    .i_w_ena     (w_ena),
    .i_w_addr    (w_addr),
    .i_w_data    (w_data),
    .o_a_data    (a_data),
    .o_b_data    (b_data),
    .o_depth     (depth),
    .o_full      (full),
    .o_empty     (empty),
    .o_overflow  (ovf),
    .o_underflow (unf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cmd   = 2'd0;
    w_ena = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick();
    a_addr = 5'd5; b_addr = 5'd31; #1;
    tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL reset_a got %h exp 0", a_data); end
    tests++; if (b_data !== 32'h0) begin fails++; $display("FAIL reset_b got %h exp 0", b_data); end
    tests++; if ({depth, empty, full, ovf, unf} !== {2'd0, 4'b1000}) begin
      fails++; $display("FAIL reset_status got d=%0d e=%b f=%b o=%b u=%b exp d=0 e=1 f=0 o=0 u=0",
                        depth, empty, full, ovf, unf);
    end
  endtask

  task automatic test_write();
    w_ena = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF; tick();
    a_addr = 5'd5; #1;
    tests++; if (a_data !== 32'hDEADBEEF) begin fails++; $display("FAIL write_x5 got %h exp deadbeef", a_data); end
    w_ena = 1'b1; w_addr = 5'd0; w_data = 32'h1234; tick();
    a_addr = 5'd0; #1;
    tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL write_x0 got %h exp 0", a_data); end
  endtask

  task automatic test_push_pop();
    w_ena = 1'b1; w_addr = 5'd5; w_data = 32'hA; tick();
    cmd = 2'd1; tick();
    a_addr = 5'd5; #1;
    tests++; if (a_data !== 32'h0 || depth !== 2'd1) begin
      fails++; $display("FAIL push_frame got x5=%h d=%0d exp x5=0 d=1", a_data, depth);
    end
    w_ena = 1'b1; w_addr = 5'd5; w_data = 32'hB; tick();
    #1;
    tests++; if (a_data !== 32'hB) begin fails++; $display("FAIL inner_write got %h exp b", a_data); end
    cmd = 2'd2; tick();
    #1;
    tests++; if (a_data !== 32'hA || depth !== 2'd0) begin
      fails++; $display("FAIL pop_frame got x5=%h d=%0d exp x5=a d=0", a_data, depth);
    end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 1; i <= 3; i++) begin
      cmd = 2'd1; tick(); #1;
      tests++; if (depth !== 2'(i) || full !== (i == 3)) begin
        fails++; $display("FAIL push_%0d got d=%0d f=%b exp d=%0d f=%b", i, depth, full, i, (i == 3));
      end
    end
    cmd = 2'd1; tick(); #1;
    tests++; if (ovf !== 1'b1 || depth !== 2'd3) begin
      fails++; $display("FAIL overflow got o=%b d=%0d exp o=1 d=3", ovf, depth);
    end
    cmd = 2'd3; tick(); #1;
    tests++; if (depth !== 2'd0 || ovf !== 1'b0 || empty !== 1'b1) begin
      fails++; $display("FAIL flush1 got d=%0d o=%b e=%b exp d=0 o=0 e=1", depth, ovf, empty);
    end
    a_addr = 5'd5; #1;
    tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL flush_mask got %h exp 0", a_data); end
    cmd = 2'd2; tick(); #1;
    tests++; if (unf !== 1'b1 || depth !== 2'd0) begin
      fails++; $display("FAIL underflow got u=%b d=%0d exp u=1 d=0", unf, depth);
    end
    cmd = 2'd1; tick(); #1;
    tests++; if (unf !== 1'b1 || depth !== 2'd1) begin
      fails++; $display("FAIL sticky_unf got u=%b d=%0d exp u=1 d=1", unf, depth);
    end
    cmd = 2'd3; tick(); #1;
    tests++; if (unf !== 1'b0 || ovf !== 1'b0 || depth !== 2'd0) begin
      fails++; $display("FAIL flush2 got u=%b o=%b d=%0d exp 0 0 0", unf, ovf, depth);
    end
  endtask

  task automatic test_write_with_cmd();
    w_ena = 1'b1; w_addr = 5'd7; w_data = 32'h55; cmd = 2'd1; tick();
    a_addr = 5'd7; #1;
    tests++; if (a_data !== 32'h0 || depth !== 2'd1) begin
      fails++; $display("FAIL push_write_new got x7=%h d=%0d exp 0 d=1", a_data, depth);
    end
    w_ena = 1'b1; w_addr = 5'd8; w_data = 32'h99; cmd = 2'd2; tick();
    #1;
    tests++; if (a_data !== 32'h55) begin fails++; $display("FAIL push_write_old got %h exp 55", a_data); end
    cmd = 2'd1; tick();
    a_addr = 5'd8; #1;
    tests++; if (a_data !== 32'h0) begin fails++; $display("FAIL pop_write_lost got %h exp 0", a_data); end
    cmd = 2'd3; tick();
  endtask

  task automatic test_same_cycle_read();
    w_ena = 1'b1; w_addr = 5'd9; w_data = 32'h11; tick();
    w_ena = 1'b1; w_addr = 5'd9; w_data = 32'h77; a_addr = 5'd9; b_addr = 5'd9; #1;
`ifdef BANKED_REGFILE_STACK_BYPASS_EN
    tests++; if (a_data !== 32'h77 || b_data !== 32'h77) begin
      fails++; $display("FAIL bypass_same got a=%h b=%h exp 77 77", a_data, b_data);
    end
`else
    tests++; if (a_data !== 32'h11 || b_data !== 32'h11) begin
      fails++; $display("FAIL nobypass_same got a=%h b=%h exp 11 11", a_data, b_data);
    end
`endif
    tick(); #1;
    tests++; if (a_data !== 32'h77 || b_data !== 32'h77) begin
      fails++; $display("FAIL read_next got a=%h b=%h exp 77 77", a_data, b_data);
    end
  endtask

  task automatic test_reset_mid();
    cmd = 2'd1; tick();
    rst = 1'b1; cmd = 2'd1; w_ena = 1'b1; w_addr = 5'd9; w_data = 32'h66; tick();
    a_addr = 5'd9; #1;
    tests++; if (depth !== 2'd0 || a_data !== 32'h0 || empty !== 1'b1) begin
      fails++; $display("FAIL reset_mid got d=%0d x9=%h e=%b exp d=0 x9=0 e=1", depth, a_data, empty);
    end
  endtask

  initial begin
    rst = 1'b1; cmd = 2'd0; w_ena = 1'b0;
    a_addr = '0; b_addr = '0; w_addr = '0; w_data = '0;
    test_reset();
    test_write();
    test_push_pop();
    test_overflow_underflow();
    test_write_with_cmd();
    test_same_cycle_read();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
